stump_seq_alu: RTL and testbench

//  Parametrised, registered successor to the Stump combinational ALU. Adds a

---
 rtl/stump_seq_alu.sv | 140 ++++++++++++++
 tb/tb_stump_seq_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stump_seq_alu.sv
// rtl/stump_seq_alu.sv - registered Stump ALU with valid/ready handshake and shift-add multiply
module stump_seq_alu #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic [2:0]       func,
  input  logic             c_in,
  input  logic             csh,
  input  logic             flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_next;

  logic [CW-1:0]        mul_cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 mul_fwe;

  logic accept, is_mul, mul_done;

  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mul   = MUL_EN && (func == 3'b111);
  assign mul_done = (state == MUL) && (mul_cnt == CNT_LAST);
  assign busy     = (state == MUL);

  logic [WIDTH-1:0] b_op, alu_r, mul_r;
  logic [WIDTH:0]   sum;
  logic             cin_op, sub_op, alu_c, alu_v;
  logic [3:0]       alu_flags, mul_flags;

  // Subtraction is A + ~B + carry; one overflow rule then covers add and sub.
  always_comb begin
    sub_op = func[1];
    b_op   = sub_op ? ~operand_B : operand_B;
    case (func[1:0])
      2'b00:   cin_op = 1'b0;
      2'b01:   cin_op = c_in;
      2'b10:   cin_op = 1'b1;
      default: cin_op = ~c_in;
    endcase
    sum   = {1'b0, operand_A} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_op};
    alu_r = sum[WIDTH-1:0];
    alu_c = sub_op ? ~sum[WIDTH] : sum[WIDTH];
    alu_v = (operand_A[WIDTH-1] == b_op[WIDTH-1]) && (alu_r[WIDTH-1] != operand_A[WIDTH-1]);
    case (func)
      3'b100: begin
        alu_r = operand_A & operand_B;
        alu_c = csh;
        alu_v = 1'b0;
      end
      3'b101: begin
        alu_r = operand_A | operand_B;
        alu_c = csh;
        alu_v = 1'b0;
      end
      3'b110, 3'b111: begin
        alu_r = operand_A;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
      default: ;
    endcase
    alu_flags = {alu_r[WIDTH-1], (alu_r == '0), alu_v, alu_c};
  end

  assign mul_r     = acc[WIDTH-1:0];
  assign mul_flags = {mul_r[WIDTH-1], (mul_r == '0), 1'b0, |acc[2*WIDTH-1:WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mul) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_out <= '0;
      mul_cnt   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_fwe   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (is_mul) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, operand_A};
            mplier  <= operand_B;
            mul_cnt <= '0;
            mul_fwe <= flag_we;
          end else begin
            result    <= alu_r;
            out_valid <= 1'b1;
            if (flag_we) flags_out <= alu_flags;
          end
        end
      end else if (mul_done) begin
        // Publish on the edge after the last iteration so acc is settled.
        result    <= mul_r;
        out_valid <= 1'b1;
        if (mul_fwe) flags_out <= mul_flags;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        mul_cnt <= mul_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stump_seq_alu.sv
// tb/tb_stump_seq_alu.sv - directed and random checks of stump_seq_alu against an arithmetic model
module tb_stump_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, c_in, csh, flag_we;
  logic         out_valid, out_ready, busy;
  logic [W-1:0] operand_A, operand_B, result;
  logic [2:0]   func;
  logic [3:0]   flags_out;

  always #5 clk = ~clk;

  stump_seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_A(operand_A), .operand_B(operand_B), .func(func),
    .c_in(c_in), .csh(csh), .flag_we(flag_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags_out(flags_out), .busy(busy)
  );

  int           checks = 0;
  int           errors = 0;
  logic [3:0]   mflags;
  logic [W-1:0] exp_r;

  // Flags {N,Z,V,C} and result from signed/unsigned integer arithmetic.
  function automatic logic [19:0] ref_op(input logic [2:0] f, input logic [15:0] a,
                                         input logic [15:0] b, input logic ci, input logic cs);
    longint s, sv, sa, sb, k;
    logic [31:0] p;
    logic [15:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = '0;
    case (f)
      3'd0, 3'd1: begin
        k  = (f == 3'd1) ? longint'(ci) : 0;
        s  = longint'(a) + longint'(b) + k;
        r  = s[15:0];
        c  = (s > 65535);
        sv = sa + sb + k;
        v  = (sv > 32767) || (sv < -32768);
      end
      3'd2, 3'd3: begin
        k  = (f == 3'd3) ? longint'(ci) : 0;
        s  = longint'(a) - longint'(b) - k;
        r  = s[15:0];
        c  = (s < 0);
        sv = sa - sb - k;
        v  = (sv > 32767) || (sv < -32768);
      end
      3'd4: begin r = a & b; c = cs; end
      3'd5: begin r = a | b; c = cs; end
      3'd6: r = a;
      default: begin
        p = {16'h0, a} * {16'h0, b};
        r = p[15:0];
        c = (p[31:16] != 16'h0);
      end
    endcase
    return {r[15], (r == 16'h0), v, c, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic cs, input logic fw);
    logic [19:0] m;
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    func = f; operand_A = a; operand_B = b; c_in = ci; csh = cs; flag_we = fw;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    m = ref_op(f, a, b, ci, cs);
    exp_r = m[15:0];
    if (fw) mflags = m[19:16];
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, {16'b0, result}, {16'b0, exp_r});
    chk({tag, "_flags"}, {28'b0, flags_out}, {28'b0, mflags});
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operand_A = '0; operand_B = '0; func = '0; c_in = 0; csh = 0; flag_we = 0;
    mflags = 4'h0; exp_r = '0;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", {16'b0, result}, 0);
    chk("rst_flags", {28'b0, flags_out}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    rst_n = 1'b1;
    tick();

    issue(3'd0, 16'h7FFF, 16'h0001, 0, 0, 1);
    chk("add_valid_next_edge", {31'b0, out_valid}, 1);
    chk("add_result", {16'b0, result}, 32'h8000);
    chk("add_flags", {28'b0, flags_out}, 32'b1010);

    issue(3'd2, 16'h0003, 16'h0005, 0, 0, 1);
    chk("sub_result", {16'b0, result}, 32'hFFFE);
    chk("sub_flags", {28'b0, flags_out}, 32'b1001);
    issue(3'd3, 16'h0010, 16'h0001, 1, 0, 1);
    chk("sbc_result", {16'b0, result}, 32'h000E);
    chk("sbc_flags", {28'b0, flags_out}, 32'b0000);

    issue(3'd7, 16'h0100, 16'h0100, 0, 0, 1);
    for (int k = 0; k < 17; k++) begin
      chk("mul_busy", {31'b0, busy}, 1);
      chk("mul_in_ready", {31'b0, in_ready}, 0);
      chk("mul_no_early_valid", {31'b0, out_valid}, 0);
      if (k < 16) tick();
    end
    tick();
    chk("mul_valid_edge17", {31'b0, out_valid}, 1);
    chk("mul_result", {16'b0, result}, 32'h0000);
    chk("mul_flags", {28'b0, flags_out}, 32'b0101);
    chk("mul_busy_done", {31'b0, busy}, 0);

    tick();
    out_ready = 1'b0;
    issue(3'd0, 16'h0001, 16'h0002, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_result", {16'b0, result}, 32'h0003);
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_in_ready", {31'b0, in_ready}, 0);
      tick();
    end
    out_ready = 1'b1;
    issue(3'd2, 16'h0001, 16'h0002, 0, 0, 1);
    chk("nobubble_valid", {31'b0, out_valid}, 1);
    chk("nobubble_result", {16'b0, result}, 32'hFFFF);
    chk("nobubble_flags", {28'b0, flags_out}, 32'b1001);
    issue(3'd5, 16'h00F0, 16'h000F, 0, 1, 0);
    chk("or_result", {16'b0, result}, 32'h00FF);
    chk("or_flags_kept", {28'b0, flags_out}, 32'b1001);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      wait_out("rand");
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        tick(); tick();
        chk("rand_hold_valid", {31'b0, out_valid}, 1);
        chk("rand_hold_result", {16'b0, result}, {16'b0, exp_r});
        out_ready = 1'b1;
      end
    end

    tick();
    issue(3'd7, 16'h1234, 16'h5678, 0, 0, 1);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_out_valid", {31'b0, out_valid}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    chk("abort_result", {16'b0, result}, 0);
    chk("abort_flags", {28'b0, flags_out}, 0);
    rst_n = 1'b1;
    mflags = 4'h0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("abort_no_stale", {31'b0, seen}, 0);
    issue(3'd1, 16'hFFFF, 16'h0000, 1, 0, 1);
    wait_out("post_reset_adc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
